csi_rx_lane_align_ctrl: RTL



---
 rtl/csi_rx_pkg.sv | 17 +
 rtl/csi_rx_lane_align_fsm.sv | 139 +++++++++++++
 rtl/csi_rx_lane_align_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/csi_rx_pkg.sv
// Shared types and defaults for the CSI-2 Rx lane word-alignment logic.
package csi_rx_pkg;

    typedef logic [7:0] lane_byte_t;

    localparam lane_byte_t SYNC_BYTE_DEF = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } lane_state_e;

endpackage

// File: rtl/csi_rx_lane_align_fsm.sv
// One lane's alignment FSM: hunts for the SoT sync byte, bitslips until it
// lands on the byte boundary, and tracks loss of lock once aligned.
module csi_rx_lane_align_fsm
    import csi_rx_pkg::*;
#(
    parameter lane_byte_t SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         SEARCH_TIMEOUT = 16,
    parameter int         SLIP_WAIT      = 4,
    parameter int         MAX_SLIPS      = 16,
    parameter int         LOSS_COUNT     = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hs_i,
    input  lane_byte_t data_i,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic       sync_hit_o
);

    localparam logic [7:0] TMO_C       = 8'(SEARCH_TIMEOUT);
    localparam logic [3:0] WAIT_LAST_C = 4'(SLIP_WAIT - 1);
    localparam logic [4:0] MAX_C       = 5'(MAX_SLIPS);
    localparam logic [2:0] LOSS_C      = 3'(LOSS_COUNT);

    lane_state_e state_q, state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [4:0]  slip_cnt_q, slip_cnt_d;
    logic [2:0]  miss_cnt_q, miss_cnt_d;
    logic        win_q, win_d;
    logic        hs_q;
    logic        bitslip_q, locked_q, fail_q;
    logic        hs_rise, sync_hit;

    assign hs_rise    = hs_i & ~hs_q;
    assign sync_hit   = hs_i & (data_i == SYNC_BYTE);
    assign sync_hit_o = sync_hit;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        slip_cnt_d = slip_cnt_q;
        miss_cnt_d = miss_cnt_q;
        win_d      = win_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_rise) begin
                    state_d    = ST_SEARCH;
                    byte_cnt_d = 8'd1;
                end
            end
            ST_SEARCH: begin
                // a hit on the timeout byte still counts as a lock
                if (sync_hit) begin
                    state_d    = ST_LOCKED;
                    slip_cnt_d = '0;
                    miss_cnt_d = '0;
                    win_d      = 1'b0;
                end else if (byte_cnt_q == TMO_C || !hs_i) begin
                    state_d = ST_SLIP;
                end else begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                end
            end
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 5'd1;
                if (slip_cnt_d == MAX_C) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d    = ST_SETTLE;
                    wait_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (wait_cnt_q == WAIT_LAST_C) state_d = ST_IDLE;
                else wait_cnt_d = wait_cnt_q + 4'd1;
            end
            ST_LOCKED: begin
                if (win_q) begin
                    if (sync_hit) begin
                        miss_cnt_d = '0;
                        win_d      = 1'b0;
                    end else if (byte_cnt_q == TMO_C || !hs_i) begin
                        win_d = 1'b0;
                        // loss of lock returns to a fresh search without slipping
                        if (miss_cnt_q + 3'd1 == LOSS_C) begin
                            state_d    = ST_IDLE;
                            slip_cnt_d = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 3'd1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end else if (hs_rise) begin
                    win_d      = 1'b1;
                    byte_cnt_d = 8'd1;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            slip_cnt_q <= '0;
            miss_cnt_q <= '0;
            win_q      <= 1'b0;
            hs_q       <= 1'b0;
            bitslip_q  <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_cnt_q <= slip_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            win_q      <= win_d;
            hs_q       <= hs_i;
            bitslip_q  <= (state_d == ST_SLIP);
            locked_q   <= (state_d == ST_LOCKED);
            fail_q     <= (state_d == ST_FAIL);
        end
    end

    assign bitslip_o = bitslip_q;
    assign locked_o  = locked_q;
    assign fail_o    = fail_q;

endmodule

// File: rtl/csi_rx_lane_align_ctrl.sv
// Word-alignment controller for all CSI-2 Rx data lanes plus the aggregate
// lock, SoT and lane-skew indications consumed by the lane merger.
module csi_rx_lane_align_ctrl
    import csi_rx_pkg::*;
#(
    parameter int         NUM_LANES      = 2,
    parameter lane_byte_t SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         SEARCH_TIMEOUT = 16,
    parameter int         SLIP_WAIT      = 4,
    parameter int         MAX_SLIPS      = 16,
    parameter int         LOSS_COUNT     = 2
) (
    input  logic                            byte_clock,
    input  logic                            reset_in,
    input  logic                            enable,
    input  logic                            serdes_rst,
    input  lane_byte_t [NUM_LANES-1:0]      lane_data,
    input  logic       [NUM_LANES-1:0]      lane_hs,
    output logic       [NUM_LANES-1:0]      bitslip,
    output logic       [NUM_LANES-1:0]      lane_locked,
    output logic       [NUM_LANES-1:0]      lane_fail,
    output logic                            all_locked,
    output logic                            sot,
    output logic                            skew_err
);

    logic                 rst;
    logic [NUM_LANES-1:0] sync_hit;
    logic                 all_locked_q, sot_q, skew_q;

    // ISERDES reset and disable both restart alignment from scratch
    assign rst = reset_in | serdes_rst | ~enable;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        csi_rx_lane_align_fsm #(
            .SYNC_BYTE      (SYNC_BYTE),
            .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
            .SLIP_WAIT      (SLIP_WAIT),
            .MAX_SLIPS      (MAX_SLIPS),
            .LOSS_COUNT     (LOSS_COUNT)
        ) u_fsm (
            .clk_i      (byte_clock),
            .rst_i      (rst),
            .hs_i       (lane_hs[g]),
            .data_i     (lane_data[g]),
            .bitslip_o  (bitslip[g]),
            .locked_o   (lane_locked[g]),
            .fail_o     (lane_fail[g]),
            .sync_hit_o (sync_hit[g])
        );
    end

    always_ff @(posedge byte_clock) begin
        if (rst) begin
            all_locked_q <= 1'b0;
            sot_q        <= 1'b0;
            skew_q       <= 1'b0;
        end else begin
            all_locked_q <= &lane_locked;
            sot_q        <= all_locked_q & (&lane_locked) & (&sync_hit);
            skew_q       <= all_locked_q & (&lane_locked) & (|sync_hit) & ~(&sync_hit);
        end
    end

    assign all_locked = all_locked_q;
    assign sot        = sot_q;
    assign skew_err   = skew_q;

endmodule
